ternary_mvm_engine: RTL and testbench

//   Streaming ternary-weight matrix-vector multiplier: y[j] = sum_i W[i][j]*x[i], W in {-1,0,+1}.

---
 rtl/tmvm_pkg.sv | 42 ++++
 rtl/ternary_col_pe.sv | 29 ++
 rtl/ternary_mvm_engine.sv | 130 +++++++++++++
 tb/tb_ternary_mvm_engine.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmvm_pkg.sv
// Shared definitions for the ternary matrix-vector engine: weight codes,
// default geometry and the per-term / saturation arithmetic helpers.
package tmvm_pkg;

    typedef enum logic [1:0] {
        W_ZERO = 2'b00,
        W_POS  = 2'b01,
        W_RSVD = 2'b10,
        W_NEG  = 2'b11
    } wcode_e;

    localparam int DEF_IN_LEN    = 16;
    localparam int DEF_OUT_LEN   = 8;
    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_LANES     = 2;

    // Works at 32 bits so negating the most negative activation cannot wrap;
    // callers narrow the result to their accumulator width.
    function automatic logic signed [31:0] ternary_term(input logic signed [31:0] act,
                                                        input logic [1:0]         code);
        case (wcode_e'(code))
            W_POS:   return act;
            W_NEG:   return -act;
            default: return 32'sd0;
        endcase
    endfunction

    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v,
                                                        input int                 w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/ternary_col_pe.sv
// One output column: sums the ternary-weighted contributions of all lanes
// of a single beat into an accumulator-width partial sum.
module ternary_col_pe
    import tmvm_pkg::*;
#(
    parameter int BitWidth = DEF_BIT_WIDTH,
    parameter int Lanes    = DEF_LANES,
    parameter int AccWidth = 13
) (
    input  logic [BitWidth*Lanes-1:0] i_act,
    input  logic [2*Lanes-1:0]        i_codes,
    output logic signed [AccWidth-1:0] o_sum
);

    logic signed [AccWidth-1:0] w_sum;
    logic signed [BitWidth-1:0] w_act;

    always_comb begin
        w_sum = '0;
        w_act = '0;
        for (int l = 0; l < Lanes; l++) begin
            w_act = signed'(i_act[l*BitWidth +: BitWidth]);
            w_sum = w_sum + AccWidth'(ternary_term(32'(w_act), i_codes[2*l +: 2]));
        end
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/ternary_mvm_engine.sv
// Streaming ternary-weight matrix-vector multiplier with a double-buffered,
// serialised output. Define TMVM_RELU_EN to store negative results as zero.
module ternary_mvm_engine
    import tmvm_pkg::*;
#(
    parameter int InLen    = DEF_IN_LEN,
    parameter int OutLen   = DEF_OUT_LEN,
    parameter int BitWidth = DEF_BIT_WIDTH,
    parameter int Lanes    = DEF_LANES,
    parameter int AccWidth = BitWidth + $clog2(InLen) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BitWidth*Lanes-1:0]   in_data,
    input  logic [2*Lanes*OutLen-1:0]   in_w,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BitWidth-1:0]  out_data,
    output logic [$clog2(OutLen)-1:0]   out_idx,
    output logic                        out_last,
    output logic                        sat_flag
);

    localparam int NB   = InLen / Lanes;
    localparam int CntW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IdxW = $clog2(OutLen);
    localparam logic [CntW-1:0] LastBeat = CntW'(NB - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(OutLen - 1);

    if (InLen % Lanes != 0) begin : g_bad_geometry
        $error("ternary_mvm_engine: InLen must be a multiple of Lanes");
    end

    logic [CntW-1:0]            r_beat_cnt;
    logic signed [AccWidth-1:0] r_acc [OutLen];
    logic signed [BitWidth-1:0] r_buf [OutLen];
    logic                       r_busy;
    logic [IdxW-1:0]            r_idx;
    logic                       r_sat;

    logic signed [AccWidth-1:0] w_part     [OutLen];
    logic signed [AccWidth-1:0] w_acc_next [OutLen];
    logic signed [BitWidth-1:0] w_store    [OutLen];
    logic [OutLen-1:0]          w_clamp;
    logic                       w_last_beat;
    logic                       w_in_fire;
    logic                       w_out_fire;
    logic                       w_free;

    for (genvar j = 0; j < OutLen; j++) begin : g_col
        logic [2*Lanes-1:0] w_codes;
        logic signed [31:0] w_sat;

        for (genvar l = 0; l < Lanes; l++) begin : g_lane
            assign w_codes[2*l +: 2] = in_w[2*(l*OutLen + j) +: 2];
        end

        ternary_col_pe #(
            .BitWidth (BitWidth),
            .Lanes    (Lanes),
            .AccWidth (AccWidth)
        ) u_pe (
            .i_act   (in_data),
            .i_codes (w_codes),
            .o_sum   (w_part[j])
        );

        // The first beat of a vector overwrites the accumulator so nothing carries over.
        assign w_acc_next[j] = (r_beat_cnt == '0) ? w_part[j] : r_acc[j] + w_part[j];
        assign w_sat         = sat_to_width(32'(w_acc_next[j]), BitWidth);
        assign w_clamp[j]    = (w_sat != 32'(w_acc_next[j]));
`ifdef TMVM_RELU_EN
        assign w_store[j]    = (w_sat < 0) ? '0 : BitWidth'(w_sat);
`else
        assign w_store[j]    = BitWidth'(w_sat);
`endif
    end

    assign w_last_beat = (r_beat_cnt == LastBeat);
    assign out_valid   = en & r_busy;
    assign out_last    = out_valid & (r_idx == LastIdx);
    assign out_idx     = r_idx;
    assign out_data    = r_buf[r_idx];
    assign sat_flag    = r_sat;
    assign w_out_fire  = out_valid & out_ready;
    assign w_free      = w_out_fire & out_last;

    // Only the closing beat waits for the buffer; it may load in the very cycle the buffer frees.
    assign in_ready  = en & ~rst & ~(w_last_beat & r_busy & ~w_free);
    assign w_in_fire = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
            r_idx      <= '0;
            r_sat      <= 1'b0;
            for (int j = 0; j < OutLen; j++) begin
                r_acc[j] <= '0;
                r_buf[j] <= '0;
            end
        end else if (en) begin
            if (w_in_fire) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
                for (int j = 0; j < OutLen; j++) begin
                    r_acc[j] <= w_acc_next[j];
                end
            end
            if (w_in_fire && w_last_beat) begin
                for (int j = 0; j < OutLen; j++) begin
                    r_buf[j] <= w_store[j];
                end
                r_busy <= 1'b1;
                r_idx  <= '0;
                r_sat  <= r_sat | (|w_clamp);
            end else if (w_out_fire) begin
                if (out_last) begin
                    r_busy <= 1'b0;
                    r_idx  <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ternary_mvm_engine.sv
// Scoreboard bench for ternary_mvm_engine: directed vectors push hand-computed
// results, an independent monitor pops and compares each output handshake.
module tb_ternary_mvm_engine;

    localparam int InLen    = 16;
    localparam int OutLen   = 8;
    localparam int BitWidth = 8;
    localparam int Lanes    = 2;
    localparam int NB       = InLen / Lanes;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       en;
    logic                       in_valid;
    logic                       in_ready;
    logic [BitWidth*Lanes-1:0]  in_data;
    logic [2*Lanes*OutLen-1:0]  in_w;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [BitWidth-1:0] out_data;
    logic [2:0]                 out_idx;
    logic                       out_last;
    logic                       sat_flag;

    ternary_mvm_engine dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
        int last;
    } exp_t;

    exp_t               expQ[$];
    exp_t               monExp;
    int                 total = 0;
    int                 bad   = 0;
    logic signed [7:0]  vecX [InLen];
    logic [1:0]         vecW [InLen][OutLen];
    int                 expVals [OutLen];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushVector();
        for (int j = 0; j < OutLen; j++) begin
            expQ.push_back('{expVals[j], j, (j == OutLen - 1) ? 1 : 0});
        end
    endtask

    task automatic setUniform(input int x, input logic [1:0] code);
        for (int i = 0; i < InLen; i++) begin
            vecX[i] = 8'(x);
            for (int j = 0; j < OutLen; j++) vecW[i][j] = code;
        end
    endtask

    task automatic driveBeat(input int k);
        for (int l = 0; l < Lanes; l++) begin
            in_data[l*BitWidth +: BitWidth] = vecX[k*Lanes + l];
            for (int j = 0; j < OutLen; j++) begin
                in_w[2*(l*OutLen + j) +: 2] = vecW[k*Lanes + l][j];
            end
        end
        in_valid = 1'b1;
    endtask

    // Presents beat k and returns just after the clock edge that accepts it.
    task automatic applyStimulus(input int k);
        int waited;
        waited = 0;
        driveBeat(k);
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                checkOutput("beat accept timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendVector();
        for (int k = 0; k < NB; k++) applyStimulus(k);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain outstanding", expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected output", 1, 0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("out_data", int'(out_data), monExp.data);
                checkOutput("out_idx", int'(out_idx), monExp.idx);
                checkOutput("out_last", int'(out_last), monExp.last);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        rst       = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        in_w      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset in_ready", int'(in_ready), 1);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset out_idx", int'(out_idx), 0);
        checkOutput("reset sat_flag", int'(sat_flag), 0);
        @(posedge clk);
        #1;

        $display("[TB] reset during beat 3");
        setUniform(1, 2'b01);
        for (int k = 0; k < 3; k++) applyStimulus(k);
        driveBeat(3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("in_ready during rst", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post-rst in_ready", int'(in_ready), 1);
        checkOutput("post-rst out_valid", int'(out_valid), 0);
        checkOutput("post-rst sat_flag", int'(sat_flag), 0);
        @(posedge clk);
        #1;

        $display("[TB] all ones");
        checkOutput("idle out_valid", int'(out_valid), 0);
        for (int j = 0; j < OutLen; j++) expVals[j] = 16;
        pushVector();
        sendVector();
        @(negedge clk);
        checkOutput("out_valid at T+1", int'(out_valid), 1);
        checkOutput("out_idx at T+1", int'(out_idx), 0);
        waitDrain();

        $display("[TB] alternating signs");
        for (int i = 0; i < InLen; i++) begin
            vecX[i] = 8'(i - 8);
            for (int j = 0; j < OutLen - 1; j++) vecW[i][j] = (i % 2 == 0) ? 2'b01 : 2'b11;
            vecW[i][OutLen-1] = 2'b10;
        end
`ifdef TMVM_RELU_EN
        for (int j = 0; j < OutLen - 1; j++) expVals[j] = 0;
`else
        for (int j = 0; j < OutLen - 1; j++) expVals[j] = -8;
`endif
        expVals[OutLen-1] = 0;
        pushVector();
        sendVector();
        waitDrain();
        checkOutput("no-clamp sat_flag", int'(sat_flag), 0);

        $display("[TB] saturation");
        setUniform(127, 2'b01);
        for (int j = 0; j < OutLen; j++) expVals[j] = 127;
        pushVector();
        sendVector();
        waitDrain();
        checkOutput("clamp sat_flag", int'(sat_flag), 1);
        setUniform(-128, 2'b11);
        for (int j = 0; j < OutLen; j++) expVals[j] = 127;
        pushVector();
        sendVector();
        waitDrain();
        setUniform(127, 2'b11);
`ifdef TMVM_RELU_EN
        for (int j = 0; j < OutLen; j++) expVals[j] = 0;
`else
        for (int j = 0; j < OutLen; j++) expVals[j] = -128;
`endif
        pushVector();
        sendVector();
        waitDrain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("sat_flag cleared by rst", int'(sat_flag), 0);
        @(posedge clk);
        #1;

        $display("[TB] back-pressure and last-beat stall");
        out_ready = 1'b0;
        setUniform(2, 2'b01);
        for (int j = 0; j < OutLen; j++) expVals[j] = 32;
        pushVector();
        sendVector();
        for (int i = 0; i < InLen; i++) begin
            vecX[i] = 8'sd3;
            for (int j = 0; j < OutLen; j++) vecW[i][j] = (j % 2 == 0) ? 2'b01 : 2'b11;
        end
`ifdef TMVM_RELU_EN
        for (int j = 0; j < OutLen; j++) expVals[j] = (j % 2 == 0) ? 48 : 0;
`else
        for (int j = 0; j < OutLen; j++) expVals[j] = (j % 2 == 0) ? 48 : -48;
`endif
        pushVector();
        for (int k = 0; k < NB - 1; k++) applyStimulus(k);
        driveBeat(NB - 1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("last beat stalls", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (out_valid && out_last) begin
                checkOutput("in_ready with A out_last", int'(in_ready), 1);
                seen = 1'b1;
            end else begin
                checkOutput("in_ready while A drains", int'(in_ready), 0);
            end
        end
        if (!seen) checkOutput("A out_last seen", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("B no bubble out_valid", int'(out_valid), 1);
        checkOutput("B no bubble out_idx", int'(out_idx), 0);
        @(posedge clk);
        #1;
        waitDrain();

        $display("[TB] enable freeze");
        for (int i = 0; i < InLen; i++) begin
            vecX[i] = 8'(i);
            for (int j = 0; j < OutLen; j++) vecW[i][j] = (i >= j) ? 2'b01 : 2'b00;
        end
        expVals = '{120, 120, 119, 117, 114, 110, 105, 99};
        pushVector();
        for (int k = 0; k < 4; k++) applyStimulus(k);
        driveBeat(4);
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("en=0 in_ready", int'(in_ready), 0);
            checkOutput("en=0 out_valid", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        for (int k = 4; k < NB; k++) applyStimulus(k);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("en=0 drain out_valid", int'(out_valid), 0);
            checkOutput("en=0 drain in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
